// File: rtl/rdn_out_stage.sv
// rdn_out_stage: output stage of the rotation-detection network.
// It captures one ROW_PIXELS x ROW_PIXELS byte image together with the
// per-bin detection vector. The image is then streamed to the rotation unit,
// one row per handshake, with the decoded rotation bin alongside each row.
//
// Optional feature: define RDN_OUT_MULTI_HIT_EN to build the multi_hit flag.
// Without the macro, multi_hit is tied low and no detection logic is built.
//
// Handshake rules:
// - A transfer happens on a rising edge where valid and ready are both high.
// - Once valid is raised, the producer keeps valid and its data stable
//   until that transfer.
// - Ready may change freely and never depends on valid in the same cycle.
// - Input side: in_ready is high only in IDLE, so an image offered while a
//   stream is in progress is not taken.
// - Output side: row_q, row_idx, last, angle, no_hit and multi_hit are
//   stable while out_valid is high and out_ready is low.
module rdn_out_stage #(
  parameter int NUM_C_NEURONS = 36,
  parameter int ROW_PIXELS    = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4:0][79:0][7:0]         d,
  input  logic [NUM_C_NEURONS-1:0]      net_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [ROW_PIXELS-1:0][7:0]    row_q,
  output logic [4:0]                    row_idx,
  output logic                          last,
  output logic [5:0]                    angle,
  output logic                          no_hit,
  output logic                          multi_hit,
  output logic                          dbg_state
);

  // The image port carries 5 groups of 80 bytes. Flattened, byte r*ROW_PIXELS+p
  // is row r, pixel p, so a row is one contiguous slice of the flat vector.
  localparam int IMG_BITS = 5 * 80 * 8;
  localparam int ROW_BITS = ROW_PIXELS * 8;
  localparam logic [4:0] LAST_IDX = 5'(ROW_PIXELS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                      state;
  logic [IMG_BITS-1:0]         img;
  logic [NUM_C_NEURONS-1:0]    net_q;
  logic                        net_loaded;
  logic [4:0]                  next_idx;

  // Pick row r out of a flattened image.
  function automatic logic [ROW_BITS-1:0] row_slice(input logic [IMG_BITS-1:0] flat,
                                                    input logic [4:0] r);
    return flat[int'(r) * ROW_BITS +: ROW_BITS];
  endfunction

  assign next_idx  = row_idx + 5'd1;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == STREAM);
  assign dbg_state = state;

  // Capture in IDLE, then walk the rows one handshake at a time in STREAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      img        <= '0;
      net_q      <= '0;
      net_loaded <= 1'b0;
      row_q      <= '0;
      row_idx    <= 5'd0;
      last       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            img        <= d;
            net_q      <= net_in;
            net_loaded <= 1'b1;
            row_q      <= row_slice(d, 5'd0);
            row_idx    <= 5'd0;
            last       <= (LAST_IDX == 5'd0);
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (last) begin
              row_idx <= 5'd0;
              last    <= 1'b0;
              state   <= IDLE;
            end else begin
              row_idx <= next_idx;
              row_q   <= row_slice(img, next_idx);
              last    <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lowest set bin wins. An empty vector decodes to bin 0.
  always_comb begin
    angle = 6'd0;
    for (int k = NUM_C_NEURONS - 1; k >= 0; k--) begin
      if (net_q[k]) angle = 6'(k);
    end
  end

  // net_loaded keeps no_hit low after reset, before any image has been taken.
  assign no_hit = net_loaded & ~(|net_q);

`ifdef RDN_OUT_MULTI_HIT_EN
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hit = |(net_q & (net_q - {{(NUM_C_NEURONS-1){1'b0}}, 1'b1}));
`else
  assign multi_hit = 1'b0;
`endif

endmodule
